// File: rtl/lighthouse_pkg.sv
// Shared types and helpers for the lighthouse beam link.
// FSM state encoding, default geometry, and the clamped half-bit length calculation.
package lighthouse_pkg;

    localparam int DEF_WORD_WIDTH      = 17;
    localparam int DEF_HALF_BIT_CYCLES = 8;
    // Wide enough for LEAD/TAIL/half-bit loads of up to 255 cycles.
    localparam int CNT_W               = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        BIT_H1,
        BIT_H2,
        TAIL
    } bmc_state_t;

    // Half-bit length = nominal + signed deviation, computed one bit wider so that
    // negative results are seen as negative rather than wrapping; floor of one cycle.
    function automatic logic [CNT_W-1:0] halfbit_len(input logic [CNT_W-1:0] half,
                                                     input logic [3:0]       dev);
        logic signed [CNT_W:0] sum;
        sum = $signed({1'b0, half}) + $signed({{(CNT_W-3){dev[3]}}, dev});
        if (sum < $signed((CNT_W+1)'(1)))
            return CNT_W'(1);
        return sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/bmc_halfbit_timer.sv
// Loadable down-counter: strobes expire on the last cycle of a loaded interval.
// Latency: expire is high exactly len cycles after the load edge.
// Backpressure: none; a load always wins and restarts the interval.
module bmc_halfbit_timer
    import lighthouse_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= len;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/bmc_beam_emulator.sv
// Beam stand-in: sends one word as a BMC burst framed by an envelope line, MSB first.
// Latency: envelope/busy rise one cycle after start is accepted; all outputs registered.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
module bmc_beam_emulator
    import lighthouse_pkg::*;
#(
    parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
    parameter int HALF_BIT_CYCLES = DEF_HALF_BIT_CYCLES,
    parameter int LEAD_CYCLES     = 16,
    parameter int TAIL_CYCLES     = 16
) (
    input  logic                  clk_25MHz,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [3:0]            deviation,
    output logic                  envelope,
    output logic                  data,
    output logic                  busy,
    output logic                  done
);

    localparam int BC_W = $clog2(WORD_WIDTH + 1);

    bmc_state_t            state, state_nxt;
    logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
    logic [BC_W-1:0]       bitcnt, bitcnt_nxt;
    logic                  env_nxt, data_nxt, busy_nxt, done_nxt;
    logic                  tmr_load, expire;
    logic [CNT_W-1:0]      tmr_len, half_len;

    // Deviation is sampled only when a half-bit is loaded, so mid-interval changes wait.
    assign half_len = halfbit_len(CNT_W'(HALF_BIT_CYCLES), deviation);

    bmc_halfbit_timer u_timer (
        .clk    (clk_25MHz),
        .rst    (reset),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (expire)
    );

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = LEAD;
            LEAD:    if (expire) state_nxt = BIT_H1;
            BIT_H1:  if (expire) state_nxt = BIT_H2;
            BIT_H2:  if (expire) state_nxt = (bitcnt == BC_W'(1)) ? TAIL : BIT_H1;
            TAIL:    if (expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tmr_load   = 1'b0;
        tmr_len    = half_len;
        env_nxt    = envelope;
        data_nxt   = data;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        case (state)
            IDLE: begin
                if (start) begin
                    tmr_load   = 1'b1;
                    tmr_len    = CNT_W'(LEAD_CYCLES);
                    env_nxt    = 1'b1;
                    data_nxt   = 1'b0;
                    busy_nxt   = 1'b1;
                    shreg_nxt  = word;
                    bitcnt_nxt = BC_W'(WORD_WIDTH);
                end
            end
            LEAD: begin
                if (expire) begin
                    tmr_load = 1'b1;
                    data_nxt = ~data;
                end
            end
            BIT_H1: begin
                if (expire) begin
                    tmr_load = 1'b1;
                    data_nxt = data ^ shreg[WORD_WIDTH-1];
                end
            end
            BIT_H2: begin
                if (expire) begin
                    tmr_load   = 1'b1;
                    data_nxt   = ~data;
                    shreg_nxt  = shreg << 1;
                    bitcnt_nxt = bitcnt - BC_W'(1);
                    if (bitcnt == BC_W'(1))
                        tmr_len = CNT_W'(TAIL_CYCLES);
                end
            end
            TAIL: begin
                // Line may be left high after the last boundary; drop it with the envelope.
                if (expire) begin
                    env_nxt  = 1'b0;
                    data_nxt = 1'b0;
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end
            end
            default: begin
                env_nxt  = 1'b0;
                data_nxt = 1'b0;
                busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            envelope <= 1'b0;
            data     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shreg    <= '0;
            bitcnt   <= '0;
        end else begin
            envelope <= env_nxt;
            data     <= data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            shreg    <= shreg_nxt;
            bitcnt   <= bitcnt_nxt;
        end
    end

endmodule

// File: tb/tb_bmc_beam_emulator.sv
// Scoreboard bench for bmc_beam_emulator: stimulus queues expected bursts, a monitor
// measures each burst on the lines and compares on envelope fall.
module tb_bmc_beam_emulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [16:0] word;
    logic [3:0]  deviation;
    logic        envelope, data, busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [16:0] word;
        int          half;
        int          trans;
        int          busyc;
        int          gap;
        bit          abort;
    } sb_entry_t;

    sb_entry_t q[$];

    bmc_beam_emulator dut (
        .clk_25MHz (clk),
        .reset     (reset),
        .start     (start),
        .word      (word),
        .deviation (deviation),
        .envelope  (envelope),
        .data      (data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, records data edges inside the envelope.
    initial begin
        int        cyc, rise_t, busy_n, low_n, mism, k, n, len, iv;
        bit        pe, pd;
        int        edges[$];
        sb_entry_t e;
        logic [16:0] dw;
        cyc = 0; rise_t = 0; busy_n = 0; low_n = 0; pe = 0; pd = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (envelope && !pe) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_burst actual=1 required=0 t=%0t", $time);
                end else if (q[0].gap >= 0) begin
                    chk("idle_gap", low_n, q[0].gap);
                end
                rise_t = cyc;
                busy_n = 0;
                edges.delete();
            end
            if (envelope && pe && (data != pd))
                edges.push_back(cyc);
            if (busy)
                busy_n++;
            if (!envelope && pe) begin
                if (q.size() != 0) begin
                    e = q.pop_front();
                    if (e.abort) begin
                        chk("abort_no_done", int'(done), 0);
                    end else begin
                        chk("done_at_fall", int'(done), 1);
                        chk("transitions", edges.size(), e.trans);
                        chk("busy_cycles", busy_n, e.busyc);
                        if (edges.size() > 0) begin
                            chk("lead_cycles", edges[0] - rise_t, 16);
                            chk("tail_cycles", cyc - edges[edges.size()-1], 16);
                        end
                        mism = 0;
                        k    = 1;
                        for (int b = 16; b >= 0; b--) begin
                            n   = e.word[b] ? 2 : 1;
                            len = e.word[b] ? e.half : 2 * e.half;
                            for (int j = 0; j < n; j++) begin
                                if (k >= edges.size() || (edges[k] - edges[k-1]) != len)
                                    mism++;
                                k++;
                            end
                        end
                        chk("spacing_mismatches", mism, 0);
                        dw = '0;
                        k  = 1;
                        for (int b = 0; b < 17; b++) begin
                            if (k < edges.size()) begin
                                iv = edges[k] - edges[k-1];
                                if (2 * iv < 3 * e.half) begin
                                    dw = {dw[15:0], 1'b1};
                                    k += 2;
                                end else begin
                                    dw = {dw[15:0], 1'b0};
                                    k += 1;
                                end
                            end
                        end
                        chk("decoded_word", int'(dw), int'(e.word));
                    end
                end
                low_n = 1;
            end else if (!envelope) begin
                low_n++;
            end
            pe = envelope;
            pd = data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [16:0] w, input int half, input int trans,
                        input int busyc, input int gap, input bit abort);
        sb_entry_t e;
        e.word = w; e.half = half; e.trans = trans; e.busyc = busyc;
        e.gap = gap; e.abort = abort;
        q.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 2000);
        chk("done_seen", int'(done), 1);
    endtask

    task automatic run_burst(input logic [16:0] w, input logic [3:0] d, input int half,
                             input int trans, input int busyc, input int pulses);
        push(w, half, trans, busyc, -1, 1'b0);
        @(negedge clk);
        word = w; deviation = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        word  = ~w;
        for (int p = 0; p < pulses; p++) begin
            repeat (40) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; word = '0; deviation = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_envelope", int'(envelope), 0);
        chk("rst_data",     int'(data),     0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_done",     int'(done),     0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // word, deviation, half-bit, transitions, busy cycles, stray start pulses
        run_burst(17'h0E5E9, 4'd0,    8,  28, 304, 2);
        run_burst(17'h00000, 4'd0,    8,  18, 304, 0);
        run_burst(17'h1FFFF, 4'd0,    8,  35, 304, 0);
        run_burst(17'h0E5E9, 4'd3,    11, 28, 406, 0);
        run_burst(17'h0E5E9, 4'b1101, 5,  28, 202, 0);
        run_burst(17'h0E5E9, 4'b1000, 1,  28, 66,  0);
        deviation = '0;

        // start held high: three bursts separated by a single envelope-low cycle
        push(17'h0E5E9, 8, 28, 304, -1, 1'b0);
        push(17'h0E5E9, 8, 28, 304, 1, 1'b0);
        push(17'h0E5E9, 8, 28, 304, 1, 1'b0);
        @(negedge clk);
        word = 17'h0E5E9; start = 1'b1;
        for (int i = 0; i < 3; i++)
            wait_done();
        start = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset during the second half of bit 5
        push(17'h0E5E9, 8, 0, 0, -1, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (107) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_envelope", int'(envelope), 0);
        chk("abort_data",     int'(data),     0);
        chk("abort_busy",     int'(busy),     0);
        repeat (3) @(negedge clk);
        chk("abort_done_low", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);
        run_burst(17'h0E5E9, 4'd0, 8, 28, 304, 0);

        // two distinct words in order, well separated
        run_burst(17'h0E5E9, 4'd0, 8, 28, 304, 0);
        repeat (500) @(negedge clk);
        run_burst(17'h0F388, 4'd0, 8, 26, 304, 0);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
